// File: rtl/matmul_pkg.sv
// matmul_pkg: state encoding and width helper for the sequential matmul.
// Signed arithmetic is enabled by defining MATMUL_SIGNED_EN.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: registered multiply-accumulate, cleared when k is zero.
// MATMUL_SIGNED_EN selects two's-complement operands and products.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] sum
);

  localparam int PW = 2 * DW;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] acc;

`ifdef MATMUL_SIGNED_EN
  assign prod = $signed({{DW{a[DW-1]}}, a})
              * $signed({{DW{b[DW-1]}}, b});
  assign ext  = {{(ACC_W-PW){prod[PW-1]}}, prod};
`else
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign ext  = {{(ACC_W-PW){1'b0}}, prod};
`endif

  assign sum = (clr ? '0 : acc) + ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matmul_seq_engine.sv
// matmul_seq_engine: streaming C = A x B for NxN operands, one MAC/cycle.
// Define MATMUL_SIGNED_EN for two's-complement arithmetic (in matmul_mac).
module matmul_seq_engine
  import matmul_pkg::*;
#(
  parameter int  N     = 3,
  parameter int  DW    = 8,
  localparam int ACC_W = acc_width(N, DW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int NN = N * N;
  localparam int KW = $clog2(N);
  localparam int CW = $clog2(NN);
  localparam int OW = $clog2(2 * NN);

  localparam logic [KW-1:0] KMAX = KW'(N - 1);
  localparam logic [CW-1:0] CMAX = CW'(NN - 1);
  localparam logic [CW-1:0] C0   = '0;
  localparam logic [OW-1:0] OMAX = OW'(2 * NN - 1);

  state_t state_q, state_d;

  logic [OW-1:0]    ld_cnt;
  logic [KW-1:0]    i_q, j_q, k_q;
  logic [CW-1:0]    idx_q;
  logic [DW-1:0]    op_mem [2*NN];
  logic [ACC_W-1:0] c_mem  [NN];

  logic             in_fire, out_fire, run;
  logic             last_in, last_mac, last_out, k_last;
  logic [OW-1:0]    a_addr, b_addr;
  logic [CW-1:0]    c_addr;
  logic [ACC_W-1:0] mac_sum;

  assign in_ready  = (state_q == LOAD) && !abort;
  assign out_valid = (state_q == OUTPUT) && !abort;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign run       = (state_q == COMPUTE) && !abort;

  assign last_in  = (ld_cnt == OMAX);
  assign k_last   = (k_q == KMAX);
  assign last_mac = k_last && (j_q == KMAX) && (i_q == KMAX);
  assign last_out = (idx_q == CMAX);

  // A is stored first, B follows at offset N*N
  assign a_addr = OW'(int'(i_q) * N + int'(k_q));
  assign b_addr = OW'(NN + int'(k_q) * N + int'(j_q));
  assign c_addr = CW'(int'(i_q) * N + int'(j_q));

  matmul_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (k_q == '0),
    .a     (op_mem[a_addr]),
    .b     (op_mem[b_addr]),
    .sum   (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD:    if (in_fire && last_in)   state_d = COMPUTE;
        COMPUTE: if (last_mac)             state_d = OUTPUT;
        OUTPUT:  if (out_fire && last_out) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != LOAD);
      done    <= out_fire && last_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      idx_q  <= '0;
    end else if (abort) begin
      ld_cnt <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      idx_q  <= '0;
    end else begin
      if (in_fire) begin
        ld_cnt <= last_in ? '0 : ld_cnt + 1'b1;
      end
      if (state_q == COMPUTE) begin
        k_q <= k_last ? '0 : k_q + 1'b1;
        if (k_last) begin
          j_q <= (j_q == KMAX) ? '0 : j_q + 1'b1;
          if (j_q == KMAX) begin
            i_q <= (i_q == KMAX) ? '0 : i_q + 1'b1;
          end
        end
      end
      if (out_fire) begin
        idx_q <= last_out ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      op_mem[ld_cnt] <= in_data;
    end
    if (run && k_last) begin
      c_mem[c_addr] <= mac_sum;
    end
  end

  // out_data is preloaded with C[0] so it is valid on the first OUTPUT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (run && last_mac) begin
      out_data <= c_mem[C0];
    end else if (out_fire && !last_out) begin
      out_data <= c_mem[idx_q + 1'b1];
    end
  end

endmodule

// File: tb/tb_matmul_seq_engine.sv
// tb_matmul_seq_engine: directed checks of the streaming matmul engine,
// an N=3/DW=8 instance plus an N=4/DW=4 instance for back-to-back jobs.
`timescale 1ns/1ps
module tb_matmul_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data3;
  logic        in_valid3, in_ready3, abort3;
  logic [17:0] out_data3;
  logic        out_valid3, out_ready3, busy3, done3;

  logic [3:0]  in_data4;
  logic        in_valid4, in_ready4, abort4;
  logic [9:0]  out_data4;
  logic        out_valid4, out_ready4, busy4, done4;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int done_cnt3 = 0;
  int done_cyc3 = 0;
  int done_cnt4 = 0;
  int first_cyc3 = 0;
  int first_out3 = -1;

  int v_id[18], v_full[18], v_diag[18], v_bp[18];
  int e_id[9], e_full[9], e_diag[9], e_bp[9];
  int j1[32], j2[32], r1[16], r2[16];

  matmul_seq_engine #(.N(3), .DW(8)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .abort     (abort3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .busy      (busy3),
    .done      (done3)
  );

  matmul_seq_engine #(.N(4), .DW(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .abort     (abort4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .busy      (busy4),
    .done      (done4)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done3) begin
      done_cnt3++;
      done_cyc3 = cyc;
    end
    if (done4) done_cnt4++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic send3(input int w[18], input int bub);
    int n = 0;
    int t = 0;
    while (n < 18 && t < 1000) begin
      @(negedge clk);
      in_valid3 = ($urandom_range(99) >= bub);
      in_data3  = 8'(w[n]);
      #1;
      if (in_valid3 && in_ready3) begin
        if (n == 0) first_cyc3 = cyc;
        n++;
      end
      t++;
    end
    chk("send3_beats", n, 18);
    @(negedge clk);
    in_valid3 = 1'b0;
  endtask

  task automatic recv3(input int exp[9], input int rdy, input int lim,
                       input string tag);
    int n = 0;
    int t = 0;
    logic [17:0] held = '0;
    logic stall = 1'b0;
    first_out3 = -1;
    while (n < lim && t < 3000) begin
      @(negedge clk);
      if (stall && out_valid3) chk({tag, "_hold"}, out_data3, held);
      stall = 1'b0;
      out_ready3 = ($urandom_range(99) < rdy);
      #1;
      if (out_valid3) begin
        if (first_out3 < 0) first_out3 = cyc;
        if (out_ready3) begin
          chk(tag, out_data3, exp[n]);
          n++;
        end else begin
          held  = out_data3;
          stall = 1'b1;
        end
      end
      t++;
    end
    chk({tag, "_count"}, n, lim);
  endtask

  task automatic finish3(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, done3, 1);
    chk({tag, "_busy"}, busy3, 0);
    chk({tag, "_rdy"}, in_ready3, 1);
    out_ready3 = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_done_end"}, done3, 0);
  endtask

  task automatic send4(input int w[32]);
    int n = 0;
    int t = 0;
    while (n < 32 && t < 1000) begin
      @(negedge clk);
      in_valid4 = 1'b1;
      in_data4  = 4'(w[n]);
      #1;
      if (in_ready4) n++;
      t++;
    end
    chk("send4_beats", n, 32);
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic recv4(input int exp[16], input string tag);
    int n = 0;
    int t = 0;
    while (n < 16 && t < 3000) begin
      @(negedge clk);
      out_ready4 = ($urandom_range(99) < 50);
      #1;
      if (out_valid4 && out_ready4) begin
        chk(tag, out_data4, exp[n]);
        n++;
      end
      t++;
    end
    chk({tag, "_count"}, n, 16);
  endtask

  function automatic void mm4(input int w[32], output int c[16]);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        c[i*4+j] = 0;
        for (int k = 0; k < 4; k++) begin
          c[i*4+j] += w[i*4+k] * w[16+k*4+j];
        end
      end
    end
  endfunction

  initial begin
    v_id   = '{1,0,0, 0,1,0, 0,0,1, 1,2,3, 4,5,6, 7,8,9};
    e_id   = '{1,2,3,4,5,6,7,8,9};
    v_full = '{default: 255};
    v_diag = '{255,0,0, 0,255,0, 0,0,255, 1,2,3, 4,5,6, 7,8,9};
    v_bp   = '{1,2,3, 4,5,6, 7,8,9, 9,8,7, 6,5,4, 3,2,1};
    e_bp   = '{30,24,18, 84,69,54, 138,114,90};
`ifdef MATMUL_SIGNED_EN
    e_full = '{default: 3};
    for (int n = 0; n < 9; n++) e_diag[n] = 262144 - (n + 1);
`else
    e_full = '{default: 195075};
    for (int n = 0; n < 9; n++) e_diag[n] = 255 * (n + 1);
`endif
    for (int n = 0; n < 32; n++) begin
      j1[n] = n % 8;
      j2[n] = (3 * n + 1) % 8;
    end
    mm4(j1, r1);
    mm4(j2, r2);

    rst_n = 1'b0;
    in_data3 = '0; in_valid3 = 1'b0; abort3 = 1'b0; out_ready3 = 1'b0;
    in_data4 = '0; in_valid4 = 1'b0; abort4 = 1'b0; out_ready4 = 1'b0;
    #1;
    chk("rst_in_ready", in_ready3, 1);
    chk("rst_out_valid", out_valid3, 0);
    chk("rst_out_data", out_data3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send3(v_id, 0);
    recv3(e_id, 100, 9, "ident");
    finish3("ident");
    chk("ident_first_valid", first_out3 - first_cyc3, 45);
    chk("ident_done_cycle", done_cyc3 - first_cyc3, 54);
    chk("ident_done_cnt", done_cnt3, 1);

    send3(v_full, 0);
    recv3(e_full, 100, 9, "full");
    finish3("full");

    send3(v_diag, 0);
    recv3(e_diag, 100, 9, "diag");
    finish3("diag");

    send3(v_bp, 30);
    recv3(e_bp, 30, 9, "bp");
    finish3("bp");
    chk("bp_done_cnt", done_cnt3, 4);

    send3(v_bp, 0);
    repeat (10) @(negedge clk);
    abort3 = 1'b1;
    #1;
    chk("abc_in_ready", in_ready3, 0);
    chk("abc_busy_pre", busy3, 1);
    @(negedge clk);
    abort3 = 1'b0;
    #1;
    chk("abc_busy", busy3, 0);
    chk("abc_in_ready_post", in_ready3, 1);
    chk("abc_done_cnt", done_cnt3, 4);
    send3(v_id, 20);
    recv3(e_id, 60, 9, "abc_fresh");
    finish3("abc_fresh");

    send3(v_bp, 0);
    recv3(e_bp, 100, 4, "abo");
    @(negedge clk);
    abort3 = 1'b1;
    out_ready3 = 1'b1;
    #1;
    chk("abo_out_valid", out_valid3, 0);
    @(negedge clk);
    abort3 = 1'b0;
    #1;
    chk("abo_busy", busy3, 0);
    chk("abo_in_ready", in_ready3, 1);
    chk("abo_out_valid_post", out_valid3, 0);
    out_ready3 = 1'b0;
    chk("abo_done_cnt", done_cnt3, 5);
    send3(v_full, 0);
    recv3(e_full, 100, 9, "abo_fresh");
    finish3("abo_fresh");

    send3(v_bp, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy3, 0);
    chk("mrst_in_ready", in_ready3, 1);
    chk("mrst_out_data", out_data3, 0);
    chk("mrst_out_valid", out_valid3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send3(v_id, 0);
    recv3(e_id, 100, 9, "mrst_fresh");
    finish3("mrst_fresh");
    chk("total_done_cnt", done_cnt3, 7);

    send4(j1);
    recv4(r1, "b2b_job1");
    send4(j2);
    recv4(r2, "b2b_job2");
    @(negedge clk);
    #1;
    chk("b2b_done_cnt", done_cnt4, 2);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
